fifo_flex: RTL and testbench

Parametrised synchronous FIFO, the next generation of the team's 2-bit fixed FIFO: configurable data width and any depth ≥ 2, including non-power-of-two depths.
- First-word-fall-through output.
- Occupancy count output.
- Programmable almost-full / almost-empty flags.
- Defined behaviour for simultaneous push/pop at full and empty.
Sits between producer/consumer stages in the examples and datapath designs; single clock domain.

---
 rtl/fifo_flex_pkg.sv | 29 ++
 rtl/fifo_flex_ram.sv | 26 ++
 rtl/fifo_flex.sv | 125 ++++++++++++
 tb/tb_fifo_flex.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_flex_pkg.sv
// Shared helpers for fifo_flex: pointer/count width derivation and the wrapping pointer increment.
package fifo_flex_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int ptr_w(input int depth);
    return clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

  // Explicit compare so non-power-of-two depths wrap at DEPTH-1.
  function automatic int ptr_next(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_flex_ram.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fifo_flex_ram
  import fifo_flex_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH      = 4,
  parameter int AW         = ptr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/fifo_flex.sv
// Synchronous FWFT FIFO, any DEPTH >= 2; registered flags from next-state count, zero-cycle fall-through.
// Push at full is accepted only alongside a pop; optional sticky overflow/underflow under FIFO_FLEX_ERR_EN.
module fifo_flex
  import fifo_flex_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     din,
  input  logic                      push,
  input  logic                      pop,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_empty,
  output logic                      almost_full,
  output logic [cnt_w(DEPTH)-1:0]   count
`ifdef FIFO_FLEX_ERR_EN
  ,
  input  logic                      err_clr,
  output logic                      overflow,
  output logic                      underflow
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);

  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_ae;
  logic                  r_af;
  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic [CW-1:0]         w_count_nxt;
  logic [DATA_WIDTH-1:0] w_rdata;

  // At full, a coincident pop frees the slot the push writes into.
  assign w_push_ok = push & (~r_full | pop);
  assign w_pop_ok  = pop & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_ae     <= 1'b1;
      r_af     <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= PW'(ptr_next(int'(r_wr_ptr), DEPTH));
      if (w_pop_ok)  r_rd_ptr <= PW'(ptr_next(int'(r_rd_ptr), DEPTH));
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == C_DEPTH);
      r_ae    <= (w_count_nxt <= C_AE);
      r_af    <= (w_count_nxt >= C_AF);
    end
  end

  fifo_flex_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW)
  ) u_ram (
    .clk   (clk),
    .we    (w_push_ok),
    .waddr (r_wr_ptr),
    .wdata (din),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  assign dout         = r_empty ? '0 : w_rdata;
  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_ae;
  assign almost_full  = r_af;
  assign count        = r_count;

`ifdef FIFO_FLEX_ERR_EN
  logic r_overflow;
  logic r_underflow;
  logic w_ovf_set;
  logic w_unf_set;

  // A push+pop on empty is a legal push, so it does not count as underflow.
  assign w_ovf_set = push & r_full & ~pop;
  assign w_unf_set = pop & r_empty & ~push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_set | (r_overflow & ~err_clr);
      r_underflow <= w_unf_set | (r_underflow & ~err_clr);
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// Self-checking bench for fifo_flex: DEPTH 4, 3 and 8 instances; directed table, corner sequences,
// queue-based reference model under random traffic; error stickies when FIFO_FLEX_ERR_EN is defined.
module tb_fifo_flex;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // DEPTH=4, DATA_WIDTH=2
  logic       push_4, pop_4, empty_4, full_4, ae_4, af_4;
  logic [1:0] din_4, dout_4;
  logic [2:0] count_4;
  // DEPTH=3, DATA_WIDTH=2
  logic       push_3, pop_3, empty_3, full_3, ae_3, af_3;
  logic [1:0] din_3, dout_3;
  logic [1:0] count_3;
  // DEPTH=8, DATA_WIDTH=4, AF=6, AE=2
  logic       push_8, pop_8, empty_8, full_8, ae_8, af_8;
  logic [3:0] din_8, dout_8;
  logic [3:0] count_8;
`ifdef FIFO_FLEX_ERR_EN
  logic err_clr_4, ovf_4, unf_4;
  logic err_clr_3, ovf_3, unf_3;
  logic err_clr_8, ovf_8, unf_8;
`endif

  fifo_flex #(.DATA_WIDTH(2), .DEPTH(4)) u4 (
    .clk(clk), .reset(reset), .din(din_4), .push(push_4), .pop(pop_4), .dout(dout_4),
    .empty(empty_4), .full(full_4), .almost_empty(ae_4), .almost_full(af_4), .count(count_4)
`ifdef FIFO_FLEX_ERR_EN
    , .err_clr(err_clr_4), .overflow(ovf_4), .underflow(unf_4)
`endif
  );

  fifo_flex #(.DATA_WIDTH(2), .DEPTH(3)) u3 (
    .clk(clk), .reset(reset), .din(din_3), .push(push_3), .pop(pop_3), .dout(dout_3),
    .empty(empty_3), .full(full_3), .almost_empty(ae_3), .almost_full(af_3), .count(count_3)
`ifdef FIFO_FLEX_ERR_EN
    , .err_clr(err_clr_3), .overflow(ovf_3), .underflow(unf_3)
`endif
  );

  fifo_flex #(.DATA_WIDTH(4), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) u8 (
    .clk(clk), .reset(reset), .din(din_8), .push(push_8), .pop(pop_8), .dout(dout_8),
    .empty(empty_8), .full(full_8), .almost_empty(ae_8), .almost_full(af_8), .count(count_8)
`ifdef FIFO_FLEX_ERR_EN
    , .err_clr(err_clr_8), .overflow(ovf_8), .underflow(unf_8)
`endif
  );

  typedef struct {
    logic       push;
    logic       pop;
    logic [1:0] din;
    logic [1:0] dout;
    logic [1:0] cnt;
    logic       empty;
    logic       full;
  } vec_t;

  function automatic vec_t mk(input bit pu, input bit po, input int di, input int dq,
                              input int c, input bit e, input bit f);
    vec_t v;
    v.push  = pu;
    v.pop   = po;
    v.din   = 2'(di);
    v.dout  = 2'(dq);
    v.cnt   = 2'(c);
    v.empty = e;
    v.full  = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    push_4 = 0; pop_4 = 0; din_4 = 0;
    push_3 = 0; pop_3 = 0; din_3 = 0;
    push_8 = 0; pop_8 = 0; din_8 = 0;
`ifdef FIFO_FLEX_ERR_EN
    err_clr_4 = 0; err_clr_3 = 0; err_clr_8 = 0;
`endif
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  vec_t tbl[15];
  logic [1:0] q3[$];
  logic [3:0] q8[$];

  initial begin
    bit pu_ok, po_ok;
    reset = 1'b1;
    idle_all();
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    check("rst u4 empty", 32'(empty_4), 1);
    check("rst u4 full", 32'(full_4), 0);
    check("rst u4 ae", 32'(ae_4), 1);
    check("rst u4 af", 32'(af_4), 0);
    check("rst u4 dout", 32'(dout_4), 0);
    check("rst u4 count", 32'(count_4), 0);
    check("rst u3 count", 32'(count_3), 0);
    check("rst u8 empty", 32'(empty_8), 1);
`ifdef FIFO_FLEX_ERR_EN
    check("rst u4 ovf", 32'(ovf_4), 0);
    check("rst u4 unf", 32'(unf_4), 0);
`endif

    // DEPTH=4: push 1,2 then two pops
    push_4 = 1; din_4 = 1; tick();
    check("t1 fwft dout", 32'(dout_4), 1);
    check("t1 fwft empty", 32'(empty_4), 0);
    din_4 = 2; tick();
    push_4 = 0;
    check("t1 dout", 32'(dout_4), 1);
    check("t1 count", 32'(count_4), 2);
    pop_4 = 1; tick();
    check("t1 pop1 dout", 32'(dout_4), 2);
    check("t1 pop1 count", 32'(count_4), 1);
    tick();
    pop_4 = 0;
    check("t1 pop2 empty", 32'(empty_4), 1);
    check("t1 pop2 dout", 32'(dout_4), 0);
    check("t1 pop2 count", 32'(count_4), 0);

    // DEPTH=8 AF=6 AE=2 thresholds
    push_8 = 1;
    for (int k = 1; k <= 7; k++) begin
      din_8 = 4'(k);
      tick();
      check($sformatf("t4 push%0d count", k), 32'(count_8), 32'(k));
      check($sformatf("t4 push%0d ae", k), 32'(ae_8), 32'(k <= 2));
      check($sformatf("t4 push%0d af", k), 32'(af_8), 32'(k >= 6));
    end
    push_8 = 0; pop_8 = 1;
    for (int c = 6; c >= 2; c--) begin
      tick();
      check($sformatf("t4 pop c%0d count", c), 32'(count_8), 32'(c));
      check($sformatf("t4 pop c%0d ae", c), 32'(ae_8), 32'(c <= 2));
      check($sformatf("t4 pop c%0d af", c), 32'(af_8), 32'(c >= 6));
      check($sformatf("t4 pop c%0d dout", c), 32'(dout_8), 32'(8 - c));
    end
    pop_8 = 0;

    // DEPTH=3 table: fill, drop at full, push+pop at full with wrap, drain, empty push+pop
    tbl[0]  = mk(1, 0, 1, 1, 1, 0, 0);
    tbl[1]  = mk(1, 0, 2, 1, 2, 0, 0);
    tbl[2]  = mk(1, 0, 3, 1, 3, 0, 1);
    tbl[3]  = mk(1, 0, 0, 1, 3, 0, 1);
    tbl[4]  = mk(1, 1, 0, 2, 3, 0, 1);
    tbl[5]  = mk(1, 1, 1, 3, 3, 0, 1);
    tbl[6]  = mk(1, 1, 2, 0, 3, 0, 1);
    tbl[7]  = mk(1, 1, 3, 1, 3, 0, 1);
    tbl[8]  = mk(1, 1, 0, 2, 3, 0, 1);
    tbl[9]  = mk(0, 1, 0, 3, 2, 0, 0);
    tbl[10] = mk(0, 1, 0, 0, 1, 0, 0);
    tbl[11] = mk(0, 1, 0, 0, 0, 1, 0);
    tbl[12] = mk(0, 1, 0, 0, 0, 1, 0);
    tbl[13] = mk(1, 1, 3, 3, 1, 0, 0);
    tbl[14] = mk(0, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 15; i++) begin
      push_3 = tbl[i].push; pop_3 = tbl[i].pop; din_3 = tbl[i].din;
      tick();
      check($sformatf("vec%0d dout", i), 32'(dout_3), 32'(tbl[i].dout));
      check($sformatf("vec%0d count", i), 32'(count_3), 32'(tbl[i].cnt));
      check($sformatf("vec%0d empty", i), 32'(empty_3), 32'(tbl[i].empty));
      check($sformatf("vec%0d full", i), 32'(full_3), 32'(tbl[i].full));
      check($sformatf("vec%0d ae", i), 32'(ae_3), 32'(tbl[i].cnt <= 1));
      check($sformatf("vec%0d af", i), 32'(af_3), 32'(tbl[i].cnt >= 2));
    end
    idle_all();

    // Mid-stream async reset with count=3
    push_4 = 1;
    for (int k = 1; k <= 3; k++) begin
      din_4 = 2'(k);
      tick();
    end
    push_4 = 0;
    check("t5 pre count", 32'(count_4), 3);
    #1 reset = 1'b1;
    #1;
    check("t5 async count", 32'(count_4), 0);
    check("t5 async empty", 32'(empty_4), 1);
    check("t5 async dout", 32'(dout_4), 0);
    check("t5 async full", 32'(full_4), 0);
    check("t5 async ae", 32'(ae_4), 1);
    #1 reset = 1'b0;
    push_4 = 1; din_4 = 2; tick();
    push_4 = 0;
    check("t5 post dout", 32'(dout_4), 2);
    check("t5 post count", 32'(count_4), 1);

    // Random traffic on DEPTH=3 and DEPTH=8 against queue models
    q3.delete();
    q8.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      int thr;
      thr = ((cyc / 40) % 2 == 0) ? 75 : 30;
      push_3 = ($urandom_range(0, 99) < thr);
      pop_3  = ($urandom_range(0, 99) < 110 - thr);
      din_3  = 2'($urandom);
      push_8 = ($urandom_range(0, 99) < thr);
      pop_8  = ($urandom_range(0, 99) < 110 - thr);
      din_8  = 4'($urandom);
      tick();
      pu_ok = push_3 && (q3.size() < 3 || pop_3);
      po_ok = pop_3 && q3.size() > 0;
      if (po_ok) void'(q3.pop_front());
      if (pu_ok) q3.push_back(din_3);
      pu_ok = push_8 && (q8.size() < 8 || pop_8);
      po_ok = pop_8 && q8.size() > 0;
      if (po_ok) void'(q8.pop_front());
      if (pu_ok) q8.push_back(din_8);
      check($sformatf("rnd%0d u3 dout", cyc), 32'(dout_3), (q3.size() > 0) ? 32'(q3[0]) : 32'd0);
      check($sformatf("rnd%0d u3 count", cyc), 32'(count_3), 32'(q3.size()));
      check($sformatf("rnd%0d u3 full", cyc), 32'(full_3), 32'(q3.size() == 3));
      check($sformatf("rnd%0d u8 dout", cyc), 32'(dout_8), (q8.size() > 0) ? 32'(q8[0]) : 32'd0);
      check($sformatf("rnd%0d u8 count", cyc), 32'(count_8), 32'(q8.size()));
      check($sformatf("rnd%0d u8 empty", cyc), 32'(empty_8), 32'(q8.size() == 0));
      check($sformatf("rnd%0d u8 ae", cyc), 32'(ae_8), 32'(q8.size() <= 2));
      check($sformatf("rnd%0d u8 af", cyc), 32'(af_8), 32'(q8.size() >= 6));
    end
    idle_all();

`ifdef FIFO_FLEX_ERR_EN
    do_reset();
    push_4 = 1;
    for (int k = 0; k < 4; k++) begin
      din_4 = 2'(k);
      tick();
    end
    check("err full", 32'(full_4), 1);
    check("err ovf pre", 32'(ovf_4), 0);
    tick();
    push_4 = 0;
    check("err ovf set", 32'(ovf_4), 1);
    check("err ovf drop count", 32'(count_4), 4);
    tick();
    check("err ovf held", 32'(ovf_4), 1);
    pop_4 = 1;
    for (int k = 0; k < 4; k++) tick();
    check("err unf pre", 32'(unf_4), 0);
    tick();
    pop_4 = 0;
    check("err unf set", 32'(unf_4), 1);
    err_clr_4 = 1; tick();
    err_clr_4 = 0;
    check("err clr ovf", 32'(ovf_4), 0);
    check("err clr unf", 32'(unf_4), 0);
    push_4 = 1; pop_4 = 1; din_4 = 3; tick();
    pop_4 = 0;
    check("err pp empty count", 32'(count_4), 1);
    check("err pp empty dout", 32'(dout_4), 3);
    check("err pp empty unf", 32'(unf_4), 0);
    for (int k = 0; k < 3; k++) tick();
    check("err refill full", 32'(full_4), 1);
    err_clr_4 = 1; tick();
    err_clr_4 = 0; push_4 = 0;
    check("err set beats clr", 32'(ovf_4), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
